// File: rtl/group_pkg.sv
// group_pkg: shared types, default widths and sign-extension helper for group_accum.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package group_pkg;

   // Window state: IDLE waits for the first term of a window, ACCUM collects the rest.
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } accum_state_t;

   localparam int NUM_WIDTH_DEF   = 16;
   localparam int ACC_WIDTH_DEF   = 32;
   localparam int LEN_WIDTH_DEF   = 16;
   localparam int SHIFT_WIDTH_DEF = 5;

   // Sign-extend the low w bits of v to 64 bits; callers cast down to their width.
   function automatic logic [63:0] sext(input logic [63:0] v, input int w);
      logic [63:0] r;
      r = v;
      for (int i = 0; i < 64; i++) begin
         if (i >= w) r[i] = v[w-1];
      end
      return r;
   endfunction

endpackage

// File: rtl/group_narrow.sv
// group_narrow: arithmetic right shift of the accumulator total, then narrow to NUM_WIDTH.
// Latency: combinational. Macro GROUP_ACCUM_SATURATE_EN selects clamping instead of wrapping.
// Backpressure: none (pure function of its inputs).
module group_narrow #(
   parameter int NUM_WIDTH   = 16,
   parameter int ACC_WIDTH   = 32,
   parameter int SHIFT_WIDTH = 5
) (
   input  logic [ACC_WIDTH-1:0]   total,
   input  logic [SHIFT_WIDTH-1:0] shift,
   output logic [NUM_WIDTH-1:0]   result
);

   logic signed [ACC_WIDTH-1:0] shifted;

   // Shift amounts at or beyond the accumulator width collapse to pure sign bits.
   always_comb begin
      shifted = $signed(total) >>> shift;
      if (int'(shift) >= ACC_WIDTH) begin
         shifted = {ACC_WIDTH{total[ACC_WIDTH-1]}};
      end
   end

`ifdef GROUP_ACCUM_SATURATE_EN
   // Bits from the output sign position upward must all agree for the value to fit.
   logic [ACC_WIDTH-NUM_WIDTH:0] upper;
   assign upper = shifted[ACC_WIDTH-1:NUM_WIDTH-1];

   // Clamp out-of-range totals to the most positive / most negative NUM_WIDTH value.
   always_comb begin
      if (upper == '0 || upper == '1) begin
         result = NUM_WIDTH'(shifted);
      end else if (shifted[ACC_WIDTH-1]) begin
         result = {1'b1, {(NUM_WIDTH-1){1'b0}}};
      end else begin
         result = {1'b0, {(NUM_WIDTH-1){1'b1}}};
      end
   end
`else
   // Wrapping narrow: keep the low NUM_WIDTH bits.
   assign result = NUM_WIDTH'(shifted);
`endif

endmodule

// File: rtl/group_accum.sv
// group_accum: sums cfg_len partial sums plus one bias per window, shifts and narrows (GROUP_ACCUM_SATURATE_EN = clamp).
// Latency: result valid the cycle after the final term of a window is accepted.
// Backpressure: only a window's final term stalls, while an unaccepted result is still held.
module group_accum
   import group_pkg::*;
#(
   parameter int NUM_WIDTH   = NUM_WIDTH_DEF,
   parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
   parameter int LEN_WIDTH   = LEN_WIDTH_DEF,
   parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [LEN_WIDTH-1:0]   cfg_len,
   input  logic [NUM_WIDTH-1:0]   cfg_bias,
   input  logic [SHIFT_WIDTH-1:0] cfg_shift,
   input  logic                   up_val,
   output logic                   up_rdy,
   input  logic [NUM_WIDTH-1:0]   up_data,
   output logic                   dn_val,
   input  logic                   dn_rdy,
   output logic [NUM_WIDTH-1:0]   dn_data
);

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

   // Bias is folded into the accumulator with the first term, so only the
   // length and shift need to be held for the rest of the window.
   accum_state_t                 state;
   logic [LEN_WIDTH-1:0]         cnt;
   logic [LEN_WIDTH-1:0]         len_r;
   logic [LEN_WIDTH-1:0]         len_eff;
   logic [SHIFT_WIDTH-1:0]       shift_r;
   logic [SHIFT_WIDTH-1:0]       shift_sel;
   logic signed [ACC_WIDTH-1:0]  acc;
   logic signed [ACC_WIDTH-1:0]  acc_next;
   logic signed [ACC_WIDTH-1:0]  term_ext;
   logic signed [ACC_WIDTH-1:0]  bias_ext;
   logic                         final_pending;
   logic                         beat;
   logic [NUM_WIDTH-1:0]         narrowed;

   // A zero length means a single-term window.
   assign len_eff  = (cfg_len == '0) ? LEN_ONE : cfg_len;
   assign term_ext = ACC_WIDTH'(sext(64'(up_data), NUM_WIDTH));
   assign bias_ext = ACC_WIDTH'(sext(64'(cfg_bias), NUM_WIDTH));

   // Next accumulator value, whether the presented term closes the window,
   // and which shift applies (live config on the first term, latched after).
   always_comb begin
      final_pending = 1'b0;
      acc_next      = acc;
      shift_sel     = shift_r;
      if (state == IDLE) begin
         final_pending = (len_eff == LEN_ONE);
         acc_next      = bias_ext + term_ext;
         shift_sel     = cfg_shift;
      end else begin
         final_pending = (cnt == len_r - LEN_ONE);
         acc_next      = acc + term_ext;
      end
   end

   // Stall only a closing term that would overwrite a result nobody has taken.
   assign up_rdy = !rst && !(final_pending && dn_val && !dn_rdy);
   assign beat   = up_val && up_rdy;

   group_narrow #(
      .NUM_WIDTH   (NUM_WIDTH),
      .ACC_WIDTH   (ACC_WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH)
   ) u_narrow (
      .total  (acc_next),
      .shift  (shift_sel),
      .result (narrowed)
   );

   // Window counter, accumulator, state machine and output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         acc     <= '0;
         len_r   <= '0;
         shift_r <= '0;
         dn_val  <= 1'b0;
         dn_data <= '0;
      end else begin
         if (beat && state == IDLE) begin
            len_r   <= len_eff;
            shift_r <= cfg_shift;
         end
         if (beat && final_pending) begin
            // A new result replaces any result taken this same cycle.
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            dn_val  <= 1'b1;
            dn_data <= narrowed;
         end else begin
            if (beat) begin
               state <= ACCUM;
               cnt   <= cnt + LEN_ONE;
               acc   <= acc_next;
            end
            if (dn_val && dn_rdy) begin
               dn_val <= 1'b0;
            end
         end
      end
   end

endmodule
